// File: rtl/multicycle_adder.sv
// rtl/multicycle_adder.sv - sequential add/subtract, CHUNK bits per clock, start/busy/done handshake
`timescale 1ns/1ps
module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_partial;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;

    logic [CHUNK-1:0]   w_a_slice;
    logic [CHUNK-1:0]   w_b_slice;
    logic [CHUNK:0]     w_sum;
    logic               w_c_msb_in;
    logic               w_last;
    logic [WIDTH-1:0]   w_next_partial;

    assign w_a_slice = r_a[int'(r_idx)*CHUNK +: CHUNK];
    assign w_b_slice = r_b[int'(r_idx)*CHUNK +: CHUNK];
    assign w_sum     = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{CHUNK{1'b0}}, r_carry};
    assign w_last    = (r_idx == IDX_W'(N - 1));
    // Carry into the slice MSB recovered from its sum bit; only consumed on the top slice.
    assign w_c_msb_in = w_sum[CHUNK-1] ^ w_a_slice[CHUNK-1] ^ w_b_slice[CHUNK-1];

    always_comb begin
        w_next_partial = r_partial;
        w_next_partial[int'(r_idx)*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_partial <= '0;
            r_carry   <= 1'b0;
            r_idx     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_idx   <= '0;
                        r_state <= RUN;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    r_partial <= w_next_partial;
                    r_carry   <= w_sum[CHUNK];
                    r_idx     <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        s       <= w_next_partial;
                        cout    <= w_sum[CHUNK];
                        ovf     <= w_sum[CHUNK] ^ w_c_msb_in;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_adder.sv
// tb/tb_multicycle_adder.sv - scoreboard bench for multicycle_adder (16/4, 8/8, 32/8)
`timescale 1ns/1ps
module tb_multicycle_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        start16, sub16, cin16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, s16;
    logic        start8, sub8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, s8;
    logic        start32, sub32, cin32, busy32, done32, cout32, ovf32;
    logic [31:0] a32, b32, s32;

    multicycle_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .sub(sub16), .cin(cin16),
        .busy(busy16), .done(done16), .s(s16), .cout(cout16), .ovf(ovf16));
    multicycle_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .sub(sub8), .cin(cin8),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8));
    multicycle_adder #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .sub(sub32), .cin(cin32),
        .busy(busy32), .done(done32), .s(s32), .cout(cout32), .ovf(ovf32));

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    exp_t q32[$];
    int ncyc  = 0;
    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void cmp(string tag, exp_t e, logic [31:0] s, logic co, logic ov);
        chk({tag, " s"}, 64'(s), 64'(e.s));
        chk({tag, " cout"}, 64'(co), 64'(e.cout));
        chk({tag, " ovf"}, 64'(ov), 64'(e.ovf));
        chk({tag, " latency"}, 64'(ncyc), 64'(e.due));
    endfunction

    function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic sub, logic cin, int due);
        logic [31:0] mask;
        logic [31:0] bb;
        logic [32:0] sum;
        exp_t e;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        bb     = (sub ? ~b : b) & mask;
        sum    = {1'b0, a & mask} + {1'b0, bb} + {32'b0, sub ? 1'b1 : cin};
        e.s    = sum[31:0] & mask;
        e.cout = sum[w];
        e.ovf  = (a[w-1] == bb[w-1]) && (e.s[w-1] != a[w-1]);
        e.due  = due;
        return e;
    endfunction

    // Monitor: every done pops one expectation; a done with nothing pending is an error.
    always @(negedge clk) begin
        ncyc++;
        if (done16) begin
            if (q16.size() == 0) chk("dut16 unexpected done", 64'd1, 64'd0);
            else cmp("dut16", q16.pop_front(), {16'b0, s16}, cout16, ovf16);
        end
        if (done8) begin
            if (q8.size() == 0) chk("dut8 unexpected done", 64'd1, 64'd0);
            else cmp("dut8", q8.pop_front(), {24'b0, s8}, cout8, ovf8);
        end
        if (done32) begin
            if (q32.size() == 0) chk("dut32 unexpected done", 64'd1, 64'd0);
            else cmp("dut32", q32.pop_front(), s32, cout32, ovf32);
        end
    end

    task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin,
                        input logic [15:0] es, input logic eco, input logic eov);
        exp_t e;
        @(negedge clk); #1;
        a16 = a; b16 = b; sub16 = sub; cin16 = cin; start16 = 1'b1;
        e.s = {16'b0, es}; e.cout = eco; e.ovf = eov; e.due = ncyc + 5;
        q16.push_back(e);
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    task automatic go_sw(input int w, input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin);
        exp_t e;
        int   n;
        n = (w == 8) ? 1 : 4;
        @(negedge clk); #1;
        e = model(w, a, b, sub, cin, ncyc + n + 1);
        if (w == 8) begin
            a8 = a[7:0]; b8 = b[7:0]; sub8 = sub; cin8 = cin; start8 = 1'b1;
            q8.push_back(e);
        end else begin
            a32 = a; b32 = b; sub32 = sub; cin32 = cin; start32 = 1'b1;
            q32.push_back(e);
        end
        @(posedge clk); #1;
        start8 = 1'b0; start32 = 1'b0;
        repeat (n + 1) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   n0;
        rst_n = 1'b0;
        start16 = 0; a16 = 0; b16 = 0; sub16 = 0; cin16 = 0;
        start8 = 0;  a8 = 0;  b8 = 0;  sub8 = 0;  cin8 = 0;
        start32 = 0; a32 = 0; b32 = 0; sub32 = 0; cin32 = 0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy16), 64'd0);
        chk("reset done", 64'(done16), 64'd0);
        chk("reset s", 64'(s16), 64'd0);
        chk("reset cout", 64'(cout16), 64'd0);
        chk("reset ovf", 64'(ovf16), 64'd0);
        #1 rst_n = 1'b1;

        go16(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        @(negedge clk);
        chk("busy after accept", 64'(busy16), 64'd1);
        repeat (3) @(negedge clk);
        chk("busy last run", 64'(busy16), 64'd1);
        @(negedge clk);
        chk("done pulse", 64'(done16), 64'd1);
        chk("busy in done", 64'(busy16), 64'd0);
        @(negedge clk);
        chk("done one cycle", 64'(done16), 64'd0);

        go16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); repeat (5) @(negedge clk);
        go16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); repeat (5) @(negedge clk);
        go16(16'h0FFF, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0); repeat (5) @(negedge clk);
        go16(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0); repeat (5) @(negedge clk);
        go16(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1); repeat (5) @(negedge clk);

        // start pulsed two cycles into RUN must be dropped
        go16(16'h1000, 16'h0234, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0);
        repeat (2) @(negedge clk); #1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
        @(posedge clk); #1 start16 = 1'b0;
        repeat (6) @(negedge clk);
        chk("held result", 64'(s16), 64'h1234);

        // start held high: accepted again in each DONE cycle
        @(negedge clk); #1;
        a16 = 16'h0003; b16 = 16'h0004; sub16 = 1'b0; cin16 = 1'b0; start16 = 1'b1;
        n0 = ncyc;
        for (int i = 1; i <= 3; i++) begin
            e.s = 32'h7; e.cout = 1'b0; e.ovf = 1'b0; e.due = n0 + 5 * i;
            q16.push_back(e);
        end
        repeat (11) @(negedge clk); #1 start16 = 1'b0;
        repeat (6) @(negedge clk);

        // operands changed during RUN have no effect
        go16(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        @(negedge clk); #1;
        a16 = 16'h0000; b16 = 16'h0000; sub16 = 1'b1; cin16 = 1'b1;
        repeat (5) @(negedge clk);

        // asynchronous reset two RUN cycles into an operation
        @(negedge clk); #1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b0; cin16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1 start16 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort s", 64'(s16), 64'd0);
        chk("abort cout", 64'(cout16), 64'd0);
        chk("abort ovf", 64'(ovf16), 64'd0);
        chk("abort busy", 64'(busy16), 64'd0);
        chk("abort done", 64'(done16), 64'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        go16(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0); repeat (5) @(negedge clk);

        go_sw(8, 32'h7F, 32'h01, 1'b0, 1'b0);
        go_sw(8, 32'hFF, 32'h01, 1'b0, 1'b0);
        go_sw(8, 32'h00, 32'h01, 1'b1, 1'b0);
        go_sw(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        go_sw(32, 32'h8000_0000, 32'h1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            go_sw(8, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            go_sw(32, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("dut16 pending", 64'(q16.size()), 64'd0);
        chk("dut8 pending", 64'(q8.size()), 64'd0);
        chk("dut32 pending", 64'(q32.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
